// File: rtl/convolution_dw_3_3_pkg.sv
// convolution_dw_3_3_pkg: shared widths, buffer depths, FSM states and arithmetic helpers
package convolution_dw_3_3_pkg;
    localparam int PX_W         = 16;
    localparam int WG_W         = 16;
    localparam int Npar         = 2;
    localparam int Size_FMI_T   = 64;
    localparam int K_DW         = 9;
    localparam int FMINT_N_ELEM = Npar * Size_FMI_T;
    localparam int KDW_N_ELEM   = Npar * K_DW;
    localparam int FMDW_N_ELEM  = Npar * Size_FMI_T;
    localparam int FA_W         = $clog2(FMINT_N_ELEM + 1);
    localparam int KA_W         = $clog2(KDW_N_ELEM + 1);
    localparam int DA_W         = $clog2(FMDW_N_ELEM + 1);
    localparam int FRAC         = PX_W - 4;
    localparam logic signed [PX_W-1:0] RELU_MAX = PX_W'(6 << FRAC);

    typedef enum logic [2:0] {IDLE, LOAD_KER, LOAD_WIN, COMPUTE, WRITE, FINISHED} state_t;

    function automatic logic signed [PX_W-1:0] relu6(input logic signed [PX_W-1:0] x);
        return x < 0 ? '0 : (x > RELU_MAX ? RELU_MAX : x);
    endfunction

    function automatic logic signed [PX_W-1:0] trunc_mul(input logic signed [PX_W-1:0] a,
                                                         input logic signed [WG_W-1:0] b);
        logic signed [PX_W+WG_W-1:0] p;
        p = a * b;
        return p[2*PX_W-5:PX_W-4];
    endfunction
endpackage

// File: rtl/convolution_dw_3_3_window_reg.sv
// dw_window_reg: 9-entry load-enabled shift register, first loaded value ends in entry 0
module dw_window_reg
    import convolution_dw_3_3_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [W-1:0]            d,
    output logic [K_DW-1:0][W-1:0]  q
);
    // shift new data in at the top so raster order lands at indices 0..8
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (en) q <= {d, q[K_DW-1:1]};
    end
endmodule

// File: rtl/convolution_dw_3_3.sv
// convolution_dw_3_3: depthwise 3x3 convolution with ReLU6, stride 1 or 2, no padding
module convolution_dw_3_3
    import convolution_dw_3_3_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stride2,
    input  logic [7:0]             Tix,
    input  logic [7:0]             Tiy,
    input  logic signed [PX_W-1:0] fmint_data,
    input  logic signed [WG_W-1:0] kdw_data,
    output logic [FA_W-1:0]        fmint_addr,
    output logic [KA_W-1:0]        kdw_addr,
    output logic [DA_W-1:0]        fmdw_addr,
    output logic                   write,
    output logic                   finish,
    output logic signed [PX_W-1:0] res
);
    state_t state, nxt;
    logic [3:0] cnt;
    logic [7:0] tix, tiy, in_x, in_y, f;
    logic s2, ker_ld, win_ld, x_adv, y_adv;
    logic [9:0] step;
    logic signed [PX_W-1:0] sum, acc;
    logic [K_DW-1:0][PX_W-1:0] win;
    logic [K_DW-1:0][WG_W-1:0] wg;

    dw_window_reg #(.W(PX_W)) u_win (.clk(clk), .rst(rst), .en(win_ld), .d(fmint_data), .q(win));
    dw_window_reg #(.W(WG_W)) u_wg  (.clk(clk), .rst(rst), .en(ker_ld), .d(kdw_data),   .q(wg));

    // position stepping, read addresses and the 9-tap multiply-accumulate
    always_comb begin
        step       = {9'd0, s2} + 10'd1;
        x_adv      = {2'b0, in_x} + 10'd2 + step <= {2'b0, tix} - 10'd1;
        y_adv      = {2'b0, in_y} + 10'd2 + step <= {2'b0, tiy} - 10'd1;
        kdw_addr   = (state == LOAD_KER && cnt < 4'd9) ? KA_W'(32'(f) * K_DW + 32'(cnt)) : '0;
        fmint_addr = (state == LOAD_WIN && cnt < 4'd9)
                   ? FA_W'(32'(f) * Size_FMI_T + (32'(in_y) + 32'(cnt) / 3) * 32'(tix)
                           + 32'(in_x) + 32'(cnt) % 3)
                   : '0;
        acc = '0;
        for (int k = 0; k < K_DW; k++) acc = acc + trunc_mul(win[k], wg[k]);
        write = state == WRITE;
        res   = relu6(sum);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // next-state: kernel once per channel, then window/compute/write per output pixel
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start ? LOAD_KER : IDLE;
            LOAD_KER: nxt = cnt == 4'd9 ? LOAD_WIN : LOAD_KER;
            LOAD_WIN: nxt = cnt == 4'd9 ? COMPUTE : LOAD_WIN;
            COMPUTE:  nxt = WRITE;
            WRITE:    nxt = (x_adv || y_adv) ? LOAD_WIN : (f == 8'(Npar - 1) ? FINISHED : LOAD_KER);
            FINISHED: nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // datapath registers: tile config, counters, delayed load enables, sum, output address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; tix <= '0; tiy <= '0; s2 <= 1'b0; in_x <= '0; in_y <= '0; f <= '0;
            ker_ld <= 1'b0; win_ld <= 1'b0; sum <= '0; fmdw_addr <= '0; finish <= 1'b0;
        end else begin
            ker_ld <= state == LOAD_KER && cnt < 4'd9;
            win_ld <= state == LOAD_WIN && cnt < 4'd9;
            finish <= state == FINISHED;
            if (state == IDLE && start) begin
                tix <= Tix; tiy <= Tiy; s2 <= stride2;
                f <= '0; in_x <= '0; in_y <= '0; cnt <= '0; fmdw_addr <= '0;
            end
            if (state == LOAD_KER || state == LOAD_WIN) cnt <= cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
            if (state == COMPUTE) sum <= acc;
            if (state == WRITE) begin
                fmdw_addr <= fmdw_addr + 1'b1;
                if (x_adv) in_x <= in_x + step[7:0];
                else begin
                    in_x <= '0;
                    if (y_adv) in_y <= in_y + step[7:0];
                    else begin
                        in_y <= '0;
                        f <= f + 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_convolution_dw_3_3.sv
// tb_convolution_dw_3_3: directed and random tiles checked against a plain-arithmetic model
module tb_convolution_dw_3_3;
    import convolution_dw_3_3_pkg::*;

    logic clk = 0, rst = 1, start = 0, stride2 = 0;
    logic [7:0] Tix = 3, Tiy = 3;
    logic signed [PX_W-1:0] fmint_data = '0, res;
    logic signed [WG_W-1:0] kdw_data = '0;
    logic [FA_W-1:0] fmint_addr;
    logic [KA_W-1:0] kdw_addr;
    logic [DA_W-1:0] fmdw_addr;
    logic write, finish;

    logic [PX_W-1:0] fm [2**FA_W];
    logic [WG_W-1:0] kw [2**KA_W];
    int exp_res[$], exp_addr[$];
    int checks = 0, failures = 0;

    convolution_dw_3_3 dut (
        .clk(clk), .rst(rst), .start(start), .stride2(stride2), .Tix(Tix), .Tiy(Tiy),
        .fmint_data(fmint_data), .kdw_data(kdw_data), .fmint_addr(fmint_addr),
        .kdw_addr(kdw_addr), .fmdw_addr(fmdw_addr), .write(write), .finish(finish), .res(res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fmint_data <= fm[fmint_addr];
        kdw_data   <= kw[kdw_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int out_dim(input int ti, input logic s);
        return (ti - 3) / (s ? 2 : 1) + 1;
    endfunction

    task automatic build_expected(input int tix, input int tiy, input logic s);
        int st, a, acc, p;
        logic signed [15:0] s16;
        st = s ? 2 : 1;
        a = 0;
        exp_res.delete();
        exp_addr.delete();
        for (int ch = 0; ch < Npar; ch++)
            for (int oy = 0; oy < out_dim(tiy, s); oy++)
                for (int ox = 0; ox < out_dim(tix, s); ox++) begin
                    acc = 0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++) begin
                            p = int'($signed(fm[ch*Size_FMI_T + (oy*st + r)*tix + ox*st + c]))
                              * int'($signed(kw[ch*9 + r*3 + c]));
                            acc = acc + (p >>> 12);
                        end
                    s16 = 16'(acc);
                    exp_res.push_back(s16 < 0 ? 0 : (s16 > 16'sh6000 ? 32'h6000 : int'(s16)));
                    exp_addr.push_back(a);
                    a++;
                end
    endtask

    task automatic run_tile(input string tag, input int tix, input int tiy, input logic s);
        int lat, nf, maxk, ea, er;
        build_expected(tix, tiy, s);
        lat = Npar * (10 + 12 * out_dim(tix, s) * out_dim(tiy, s)) + 2;
        nf = 0;
        maxk = 0;
        @(negedge clk);
        Tix = 8'(tix); Tiy = 8'(tiy); stride2 = s; start = 1;
        for (int cyc = 1; cyc <= lat + 20; cyc++) begin
            @(negedge clk);
            start = cyc == 30;
            if (int'(kdw_addr) > maxk) maxk = int'(kdw_addr);
            if (write) begin
                if (exp_res.size() == 0) chk({tag, "_extra_write"}, 1, 0);
                else begin
                    er = exp_res.pop_front();
                    ea = exp_addr.pop_front();
                    chk({tag, "_res"}, 32'(res), 32'(er));
                    chk({tag, "_addr"}, 32'(fmdw_addr), 32'(ea));
                end
            end
            if (finish) begin
                nf++;
                chk({tag, "_latency"}, 32'(cyc), 32'(lat));
            end
            if (write && finish) chk({tag, "_write_and_finish"}, 1, 0);
            if (int'(fmint_addr) % Size_FMI_T >= tix * tiy) chk({tag, "_fmint_range"}, 32'(fmint_addr), 0);
        end
        chk({tag, "_finish_count"}, 32'(nf), 1);
        chk({tag, "_missing_writes"}, 32'(exp_res.size()), 0);
        chk({tag, "_max_kdw_addr"}, 32'(maxk), 32'(Npar * 9 - 1));
    endtask

    initial begin
        int bad;
        foreach (fm[i]) fm[i] = '0;
        foreach (kw[i]) kw[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_write", 32'(write), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_res", 32'(res), 0);
        chk("rst_fmdw_addr", 32'(fmdw_addr), 0);
        chk("rst_kdw_addr", 32'(kdw_addr), 0);
        chk("rst_fmint_addr", 32'(fmint_addr), 0);
        rst = 0;

        foreach (fm[i]) fm[i] = 16'h1000;
        foreach (kw[i]) kw[i] = 16'h0400;
        build_expected(3, 3, 0);
        chk("model_pos", 32'(exp_res[0]), 32'h2400);
        run_tile("pos3x3", 3, 3, 0);

        foreach (kw[i]) kw[i] = 16'hFC00;
        run_tile("neg3x3", 3, 3, 0);

        for (int ch = 0; ch < Npar; ch++) begin
            for (int i = 0; i < 25; i++) fm[ch*Size_FMI_T + i] = 16'(i + 100*ch);
            for (int k = 0; k < 9; k++) kw[ch*9 + k] = k == 4 ? 16'h1000 : 16'h0000;
        end
        build_expected(5, 5, 0);
        chk("model_centre", 32'(exp_res[4]), 12);
        run_tile("ctr5x5_s1", 5, 5, 0);
        run_tile("ctr5x5_s2", 5, 5, 1);
        run_tile("ctr6x5_s2", 6, 5, 1);

        for (int t = 0; t < 4; t++) begin
            foreach (fm[i]) fm[i] = 16'($urandom);
            foreach (kw[i]) kw[i] = 16'($urandom);
            run_tile("rand", int'($urandom_range(3, 8)), int'($urandom_range(3, 8)), 1'($urandom));
        end

        @(negedge clk);
        Tix = 5; Tiy = 5; stride2 = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        chk("midrst_write", 32'(write), 0);
        chk("midrst_finish", 32'(finish), 0);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (write || finish) bad++;
        end
        chk("midrst_quiet", 32'(bad), 0);
        run_tile("after_rst", 5, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
